reduce_stream: RTL and testbench
================================

# reduce_stream

Parametrised, clocked multi-beat bit-reduction unit: reduces a WIDTH-bit word per beat with a selectable operator (OR, AND, XOR, NOR) and accumulates across a multi-beat packet delimited by `in_last`. It generalises the fixed 8-input combinational OR into a streaming block with valid/ready handshakes on both sides. It sits between word-wide datapath sources (ALU flags, memory-scan logic) and control logic that needs a single "any/all/parity" decision over a run of words.

## Interface
- WIDTH, 16, bits per input beat (≥2)
- COUNT_W, 8, width of the beat counter
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  WIDTH  beat payload
- in_last  in  1  marks final beat of packet
- op  in  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled on first beat only
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_bit  out  1  packet reduction result
- out_beats  out  COUNT_W  beats in packet (saturating)
- out_overflow  out  1  beat count saturated

## Operation
- States: IDLE (no packet open), ACC (packet open, awaiting more beats), HOLD (result presented).
- Per-beat reduction r: OR/NOR → |in_data; AND → &in_data; XOR → ^in_data.
- IDLE, beat accepted: latch op into op_q; acc = r; cnt = 1. in_last=1 → HOLD, else → ACC.
- ACC, beat accepted: acc = acc|r (OR, NOR), acc&r (AND), acc^r (XOR) per op_q; cnt += 1. in_last=1 → HOLD, else stay.
- Entering HOLD: out_bit = acc_next (inverted for NOR), out_beats = cnt_next, out_overflow = saturation flag; out_valid = 1.
- HOLD: outputs frozen while out_ready=0. Handshake → IDLE, out_valid = 0 next cycle.
- in_ready = 1 in IDLE and ACC, 0 in HOLD and while reset is high. No beat is accepted in HOLD.
- op changes mid-packet are ignored; op_q is used until packet end.
- Counter: increments to 2^COUNT_W−1 then holds; the sticky overflow flag is set on any accepted beat while cnt is already at max. Flag clears on the next packet's first beat.
- Single-beat packet (first beat with in_last=1) is legal: IDLE → HOLD directly.
- in_valid with in_ready=0 has no effect; the source must hold data.

## Timing
- Reset (clock edge with reset=1): state IDLE; out_valid 0, out_bit 0, out_beats 0, out_overflow 0; acc, cnt and op_q cleared. Any open packet is discarded. A held result is dropped without handshake.
- in_ready is combinational from state and reset only, with no in_valid→in_ready path. Outputs are registered.
- Latency: last beat accepted at edge N → out_valid high after edge N, i.e. in cycle N+1.
- Throughput: one packet per B+1 cycles (B beats) with out_ready held high. The first beat of the next packet is accepted in the cycle after the output handshake.
- Simultaneous reset and handshake: reset wins, with no result transfer counted.

## Test plan
- WIDTH=16, OR, 3 beats 0x0000, 0x0040, 0x0000 (last on 3rd), out_ready=1 → out_valid one cycle after beat 3; out_bit=1, out_beats=3, overflow=0.
- AND, 2 beats 0xFFFF, 0xFFFE; then NOR, 1 beat 0x0000 → first result out_bit=0, beats=2. Second result out_bit=1, beats=1. in_ready=0 during each HOLD cycle.
- XOR, beats 0x0001, 0x0003, 0x8000 with op toggled to AND on beat 2 → parity 1^0^1 = 0 using latched XOR, so out_bit=0, beats=3.
- Backpressure: hold out_ready=0 for 5 cycles after result → out_valid, out_bit and out_beats stable. in_ready=0 with in_valid=1 for the whole stall. After out_ready=1, out_valid drops next cycle and in_ready rises.
- COUNT_W=4, OR, 20 beats of 0x0000 → out_beats=15, out_overflow=1, out_bit=0. The next 1-beat packet 0x0001 gives overflow=0, beats=1, out_bit=1.
- Reset asserted for 1 cycle mid-packet (after 2 of 4 beats) and again during HOLD → all outputs 0 and in_ready=1 the cycle after reset. A fresh 1-beat OR packet of 0x0000 yields out_bit=0, beats=1.

Source files
------------

// File: rtl/reduce_stream.sv
// Streaming multi-beat bit reduction (OR/AND/XOR/NOR) with valid/ready on both sides.
// Each packet is collapsed to one result bit plus a saturating beat count and an overflow flag.
module reduce_stream #(
  parameter int WIDTH   = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic [COUNT_W-1:0] out_beats,
  output logic               out_overflow
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 acc_q, acc_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 bit_q, bit_d;
  logic [COUNT_W-1:0]   beats_q, beats_d;
  logic                 oflow_q, oflow_d;
  logic                 accept;
  logic [1:0]           beat_op;
  logic                 beat_r;

  // NOR reduces like OR; the inversion is applied only when the result is presented.
  function automatic logic beat_reduce(input logic [WIDTH-1:0] d, input logic [1:0] o);
    case (o)
      OP_AND:  return &d;
      OP_XOR:  return ^d;
      default: return |d;
    endcase
  endfunction

  function automatic logic acc_merge(input logic a, input logic r, input logic [1:0] o);
    case (o)
      OP_AND:  return a & r;
      OP_XOR:  return a ^ r;
      default: return a | r;
    endcase
  endfunction

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACC: if (accept) state_d = in_last ? HOLD : ACC;
      HOLD:      if (out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = !reset && (state_q != HOLD);
    out_valid    = (state_q == HOLD);
    out_bit      = bit_q;
    out_beats    = beats_q;
    out_overflow = oflow_q;
  end

  // The operator is taken from the port only on a packet's first beat.
  always_comb begin
    op_d    = op_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bit_d   = bit_q;
    beats_d = beats_q;
    oflow_d = oflow_q;
    beat_op = (state_q == IDLE) ? op : op_q;
    beat_r  = beat_reduce(in_data, beat_op);
    if (accept) begin
      if (state_q == IDLE) begin
        op_d  = op;
        acc_d = beat_r;
        cnt_d = COUNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_merge(acc_q, beat_r, op_q);
        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
        else                  cnt_d = cnt_q + COUNT_W'(1);
      end
      if (in_last) begin
        bit_d   = (beat_op == OP_NOR) ? ~acc_d : acc_d;
        beats_d = cnt_d;
        oflow_d = ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bit_q   <= 1'b0;
      beats_q <= '0;
      oflow_q <= 1'b0;
    end else begin
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bit_q   <= bit_d;
      beats_q <= beats_d;
      oflow_q <= oflow_d;
    end
  end

endmodule

// File: tb/tb_reduce_stream.sv
// Bench for reduce_stream: directed scenarios plus random packets checked against
// a packet-level reference computed from the whole list of beats.
module tb_reduce_stream;
  localparam int WIDTH   = 16;
  localparam int COUNT_W = 4;
  localparam int MAXC    = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic [1:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic [COUNT_W-1:0] out_beats;
  logic               out_overflow;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] pkt_data[$];
  logic [1:0]       pkt_op[$];

  reduce_stream #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_beats(out_beats), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of a whole packet: operator fixed by the first beat, count saturates.
  task automatic model(output logic b, output int beats, output logic ov);
    logic any_one = 1'b0;
    logic all_one = 1'b1;
    logic parity  = 1'b0;
    int   n = pkt_data.size();
    foreach (pkt_data[i]) begin
      any_one = any_one | (pkt_data[i] != '0);
      all_one = all_one & (pkt_data[i] == '1);
      parity  = parity ^ ($countones(pkt_data[i]) % 2 == 1);
    end
    case (pkt_op[0])
      2'd0: b = any_one;
      2'd1: b = all_one;
      2'd2: b = parity;
      default: b = !any_one;
    endcase
    beats = (n > MAXC) ? MAXC : n;
    ov    = (n > MAXC);
  endtask

  task automatic send_pkt();
    int n = pkt_data.size();
    int t;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = pkt_data[i];
      op       = pkt_op[i];
      in_last  = (i == n - 1);
      if (i == n - 1) check("no_early_valid", 32'(out_valid), 32'd0);
      t = 0;
      while (!in_ready && t < 100) begin
        tick();
        t++;
      end
      if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic b, ov;
    int beats;
    model(b, beats, ov);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_bit"}, 32'(out_bit), 32'(b));
    check({tag, "_beats"}, 32'(out_beats), 32'(beats));
    check({tag, "_ovf"}, 32'(out_overflow), 32'(ov));
    check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic drain(input int hold);
    logic b0 = out_bit;
    logic [COUNT_W-1:0] c0 = out_beats;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_bit", 32'(out_bit), 32'(b0));
      check("stall_beats", 32'(out_beats), 32'(c0));
      check("stall_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_rdy", 32'(in_ready), 32'd1);
  endtask

  task automatic load(input logic [1:0] o, input logic [WIDTH-1:0] d);
    pkt_data.push_back(d);
    pkt_op.push_back(o);
  endtask

  task automatic clear();
    pkt_data.delete();
    pkt_op.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_bit"}, 32'(out_bit), 32'd0);
    check({tag, "_beats"}, 32'(out_beats), 32'd0);
    check({tag, "_ovf"}, 32'(out_overflow), 32'd0);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; op = 2'd0; out_ready = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_zero("reset");

    clear(); load(2'd0, 16'h0000); load(2'd0, 16'h0040); load(2'd0, 16'h0000);
    send_pkt(); check_result("or3"); drain(0);

    clear(); load(2'd1, 16'hFFFF); load(2'd1, 16'hFFFE);
    send_pkt(); check_result("and2"); drain(0);
    clear(); load(2'd3, 16'h0000);
    send_pkt(); check_result("nor1"); drain(0);

    clear(); load(2'd2, 16'h0001); load(2'd1, 16'h0003); load(2'd2, 16'h8000);
    send_pkt(); check_result("xor_lat"); drain(0);

    // Backpressure with the next single-beat packet waiting at the input.
    clear(); load(2'd1, 16'hFFFF);
    send_pkt(); check_result("bp");
    in_valid = 1'b1; in_data = 16'h0001; op = 2'd0; in_last = 1'b1;
    drain(5);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    clear(); load(2'd0, 16'h0001);
    check_result("bp_next"); drain(0);

    clear();
    for (int i = 0; i < 20; i++) load(2'd0, 16'h0000);
    send_pkt(); check_result("sat"); drain(0);
    clear(); load(2'd0, 16'h0001);
    send_pkt(); check_result("sat_next"); drain(0);

    // Reset in the middle of an open packet.
    in_valid = 1'b1; in_last = 1'b0; op = 2'd1; in_data = 16'hFFFF;
    tick(); tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_rdy", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_zero("rst_mid");

    // Reset during HOLD together with a handshake: no result is transferred.
    clear(); load(2'd0, 16'hFFFF);
    send_pkt(); check_result("pre_rst");
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    #1;
    check_zero("rst_hold");
    tick();
    check("rst_hold_quiet", 32'(out_valid), 32'd0);
    clear(); load(2'd0, 16'h0000);
    send_pkt(); check_result("post_rst"); drain(0);

    for (int p = 0; p < 40; p++) begin
      int n = $urandom_range(1, 20);
      clear();
      for (int i = 0; i < n; i++) begin
        logic [WIDTH-1:0] d;
        case ($urandom_range(0, 3))
          0: d = '0;
          1: d = '1;
          2: d = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
          default: d = WIDTH'($urandom);
        endcase
        load(2'($urandom_range(0, 3)), d);
      end
      send_pkt(); check_result("rnd"); drain($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
